// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time on the instruction bus and presents the IF/ID register to decode.
// A one-entry skid buffer absorbs decode stalls, and redirects from execute
// cancel any in-flight fetch (the stale response is waited for and dropped).
//
// Handshake: a bus request is live while ireq_valid=1 and completes in the
// cycle ireq_data_ok=1; ireq_addr never changes while a request is live.
// Decode takes out_* in any cycle with out_valid=1 && stall=0.
module fetch_stage #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ireq_valid,
    output logic [PC_W-1:0] ireq_addr,
    input  logic            ireq_data_ok,
    input  logic [31:0]     ireq_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_req_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_out_valid;
    logic [31:0]     r_out_inst;
    logic [PC_W-1:0] r_out_pc;
    logic            r_skid_valid;
    logic [31:0]     r_skid_inst;
    logic [PC_W-1:0] r_skid_pc;

    logic [PC_W-1:0] w_next_pc;
    logic            w_can_load;

    // Sequential PC wraps silently; IF/ID may be overwritten when empty or consumed.
    assign w_next_pc  = r_req_pc + PC_W'(4);
    assign w_can_load = !r_out_valid || !stall;

    // Bus request is decoded from state; the address is the registered req_pc.
    assign ireq_valid = (r_state == FETCH) || (r_state == DISCARD);
    assign ireq_addr  = r_req_pc;
    assign out_valid  = r_out_valid;
    assign out_inst   = r_out_inst;
    assign out_pc     = r_out_pc;
    assign dbg_state  = r_state;

    // Fetch FSM together with the PC, IF/ID register and skid buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_pc     <= RESET_PC;
            r_pend_pc    <= '0;
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_pc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_valid) begin
                        r_req_pc     <= redirect_pc;
                        r_out_valid  <= 1'b0;
                        r_skid_valid <= 1'b0;
                    end
                    r_state <= FETCH;
                end

                FETCH: begin
                    if (redirect_valid) begin
                        r_out_valid  <= 1'b0;
                        r_skid_valid <= 1'b0;
                        if (ireq_data_ok) begin
                            // Response completes now: drop it and restart at once.
                            r_req_pc <= redirect_pc;
                        end else begin
                            // Address must stay put until the bus answers.
                            r_pend_pc <= redirect_pc;
                            r_state   <= DISCARD;
                        end
                    end else if (ireq_data_ok) begin
                        r_req_pc <= w_next_pc;
                        if (w_can_load) begin
                            r_out_valid <= 1'b1;
                            r_out_inst  <= ireq_data;
                            r_out_pc    <= r_req_pc;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_inst  <= ireq_data;
                            r_skid_pc    <= r_req_pc;
                            r_state      <= HOLD;
                        end
                    end else if (!stall) begin
                        r_out_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        r_out_valid  <= 1'b0;
                        r_skid_valid <= 1'b0;
                        r_req_pc     <= redirect_pc;
                        r_state      <= FETCH;
                    end else if (!stall) begin
                        r_out_valid  <= 1'b1;
                        r_out_inst   <= r_skid_inst;
                        r_out_pc     <= r_skid_pc;
                        r_skid_valid <= 1'b0;
                        r_state      <= FETCH;
                    end
                end

                DISCARD: begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                    if (ireq_data_ok) begin
                        // A redirect arriving with the response is the newest target.
                        r_req_pc <= redirect_valid ? redirect_pc : r_pend_pc;
                        r_state  <= FETCH;
                    end else if (redirect_valid) begin
                        r_pend_pc <= redirect_pc;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step advances one clock edge, then
// checks the registered outputs against hand-computed values.
module tb_fetch_stage;

    localparam int PC_W = 64;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D1 = 32'h0040_0093;
    localparam logic [31:0] D2 = 32'h0080_0113;
    localparam logic [31:0] D3 = 32'h00c0_0193;
    localparam logic [31:0] D4 = 32'h0100_0213;
    localparam logic [31:0] D5 = 32'h0140_0293;
    localparam logic [31:0] D6 = 32'h0180_0313;
    localparam logic [31:0] D7 = 32'h01c0_0393;

    logic            clk;
    logic            rst_n;
    logic            ireq_valid;
    logic [PC_W-1:0] ireq_addr;
    logic            ireq_data_ok;
    logic [31:0]     ireq_data;
    logic            stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;
    logic [1:0]      dbg_state;

    int n_vec;
    int n_miss;

    fetch_stage #(
        .PC_W    (PC_W),
        .RESET_PC(64'h0000_0000_8000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_data_ok  (ireq_data_ok),
        .ireq_data     (ireq_data),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .dbg_state     (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are then settled for checking.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive the inputs that the next rising edge will sample.
    task automatic drive(input logic ok, input logic [31:0] data, input logic stl,
                         input logic rv, input logic [63:0] rpc);
        ireq_data_ok   = ok;
        ireq_data      = data;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // ---- Reset, then zero-wait bus ----
        step();
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        step();
        rst_n = 1'b1;
        step();  // IDLE -> FETCH: request visible in the 2nd cycle after release
        chk("a_ireq_valid", 64'(ireq_valid), 64'd1);
        chk("a_addr0", ireq_addr, 64'h8000_0000);
        chk("a_out_valid0", 64'(out_valid), 64'd0);
        drive(1'b1, D0, 1'b0, 1'b0, 64'h0);
        step();
        chk("a_out_valid1", 64'(out_valid), 64'd1);
        chk("a_out_pc1", out_pc, 64'h8000_0000);
        chk("a_out_inst1", 64'(out_inst), 64'(D0));
        chk("a_addr1", ireq_addr, 64'h8000_0004);
        drive(1'b1, D1, 1'b0, 1'b0, 64'h0);
        step();
        chk("a_out_valid2", 64'(out_valid), 64'd1);
        chk("a_out_pc2", out_pc, 64'h8000_0004);
        chk("a_out_inst2", 64'(out_inst), 64'(D1));
        chk("a_addr2", ireq_addr, 64'h8000_0008);
        drive(1'b1, D2, 1'b0, 1'b0, 64'h0);
        step();
        chk("a_out_valid3", 64'(out_valid), 64'd1);
        chk("a_out_pc3", out_pc, 64'h8000_0008);
        chk("a_out_inst3", 64'(out_inst), 64'(D2));
        chk("a_addr3", ireq_addr, 64'h8000_000C);

        // ---- Fresh reset, then stall into the skid buffer ----
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        step();
        chk("b_rst_state", 64'(dbg_state), 64'(S_IDLE));
        chk("b_rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        step();
        chk("b_addr0", ireq_addr, 64'h8000_0000);
        drive(1'b1, D0, 1'b0, 1'b0, 64'h0);
        step();
        chk("b_out_pc0", out_pc, 64'h8000_0000);
        drive(1'b1, D1, 1'b1, 1'b0, 64'h0);  // data_ok for ..04 while stalled
        step();
        chk("b_hold_state", 64'(dbg_state), 64'(S_HOLD));
        chk("b_hold_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("b_hold_out_valid", 64'(out_valid), 64'd1);
        chk("b_hold_out_pc", out_pc, 64'h8000_0000);
        chk("b_hold_out_inst", 64'(out_inst), 64'(D0));
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        step();
        chk("b_hold2_out_pc", out_pc, 64'h8000_0000);
        chk("b_hold2_ireq_valid", 64'(ireq_valid), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);  // release stall
        step();
        chk("b_rel_out_valid", 64'(out_valid), 64'd1);
        chk("b_rel_out_pc", out_pc, 64'h8000_0004);
        chk("b_rel_out_inst", 64'(out_inst), 64'(D1));
        chk("b_rel_ireq_valid", 64'(ireq_valid), 64'd1);
        chk("b_rel_addr", ireq_addr, 64'h8000_0008);

        // ---- Redirect while 0x80000008 is pending, response 3 cycles later ----
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1000);
        step();
        chk("c_state", 64'(dbg_state), 64'(S_DISCARD));
        chk("c_out_valid", 64'(out_valid), 64'd0);
        chk("c_ireq_valid", 64'(ireq_valid), 64'd1);
        chk("c_addr_hold1", ireq_addr, 64'h8000_0008);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        step();
        chk("c_addr_hold2", ireq_addr, 64'h8000_0008);
        step();
        chk("c_addr_hold3", ireq_addr, 64'h8000_0008);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);  // stale response
        step();
        chk("c_drop_out_valid", 64'(out_valid), 64'd0);
        chk("c_new_addr", ireq_addr, 64'h8000_1000);
        chk("c_new_state", 64'(dbg_state), 64'(S_FETCH));
        drive(1'b1, D3, 1'b0, 1'b0, 64'h0);
        step();
        chk("c_out_pc", out_pc, 64'h8000_1000);
        chk("c_out_inst", 64'(out_inst), 64'(D3));
        chk("c_next_addr", ireq_addr, 64'h8000_1004);

        // ---- Redirect in the same cycle as data_ok ----
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 64'h8000_2000);
        step();
        chk("d_out_valid", 64'(out_valid), 64'd0);
        chk("d_addr", ireq_addr, 64'h8000_2000);
        chk("d_state", 64'(dbg_state), 64'(S_FETCH));
        drive(1'b1, D4, 1'b0, 1'b0, 64'h0);
        step();
        chk("d_out_pc", out_pc, 64'h8000_2000);
        chk("d_out_inst", 64'(out_inst), 64'(D4));

        // ---- Two redirects during one DISCARD: latest wins ----
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h100);
        step();
        chk("e_state1", 64'(dbg_state), 64'(S_DISCARD));
        chk("e_addr1", ireq_addr, 64'h8000_2004);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h200);
        step();
        chk("e_state2", 64'(dbg_state), 64'(S_DISCARD));
        chk("e_addr2", ireq_addr, 64'h8000_2004);
        drive(1'b1, 32'hBAD1_BAD1, 1'b0, 1'b0, 64'h0);
        step();
        chk("e_addr_final", ireq_addr, 64'h200);
        chk("e_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, D5, 1'b0, 1'b0, 64'h0);
        step();
        chk("e_out_pc", out_pc, 64'h200);
        chk("e_out_inst", 64'(out_inst), 64'(D5));

        // ---- Reset in the middle of HOLD with stall=1 ----
        drive(1'b1, D6, 1'b1, 1'b0, 64'h0);
        step();
        chk("f_state", 64'(dbg_state), 64'(S_HOLD));
        chk("f_out_pc", out_pc, 64'h200);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        step();
        chk("f_rst_out_valid", 64'(out_valid), 64'd0);
        chk("f_rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("f_rst_out_pc", out_pc, 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        step();
        chk("f_restart_valid", 64'(ireq_valid), 64'd1);
        chk("f_restart_addr", ireq_addr, 64'h8000_0000);

        // ---- PC wrap at the top of the address space ----
        drive(1'b1, 32'hBAD2_BAD2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("g_addr_top", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, D7, 1'b0, 1'b0, 64'h0);
        step();
        chk("g_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("g_out_inst", 64'(out_inst), 64'(D7));
        chk("g_addr_wrap", ireq_addr, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
